// File: rtl/zx_bus_initiator_if.sv
`timescale 1ns/1ps
// zx_bus_initiator_if: Z80-style external bus between the cycle initiator (master) and memory/IO (slave).
// Carries address, split data, active-low strobes and the n_wait request.
interface zx_bus_initiator_if;
    logic [15:0] xa;
    logic [7:0]  xd_o;
    logic        xd_oe;
    logic [7:0]  xd_i;
    logic        n_mreq;
    logic        n_iorq;
    logic        n_rd;
    logic        n_wr;
    logic        n_m1;
    logic        n_wait;

    modport master (
        output xa, xd_o, xd_oe, n_mreq, n_iorq, n_rd, n_wr, n_m1,
        input  xd_i, n_wait
    );

    modport slave (
        input  xa, xd_o, xd_oe, n_mreq, n_iorq, n_rd, n_wr, n_m1,
        output xd_i, n_wait
    );
endinterface

// File: rtl/zx_bus_initiator.sv
`timescale 1ns/1ps
// zx_bus_initiator: runs one Z80-style MEM/IO read or write cycle per request, paced in half T-states from clk28.
// Define ZX_BUS_INITIATOR_WAIT_EN to honour n_wait; otherwise only the fixed I/O Tw is ever inserted.
module zx_bus_initiator #(
    parameter int unsigned HALF_DIV = 4
) (
    input  logic               clk28,
    input  logic               rst_n,
    input  logic               req,
    input  logic [1:0]         op,
    input  logic [15:0]        addr,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata,
    output logic               ack,
    output logic               busy,
    zx_bus_initiator_if.master bus
);

    localparam int unsigned       CW       = $clog2(HALF_DIV);
    localparam logic [CW-1:0]     DIV_LAST = CW'(HALF_DIV - 1);

    // H0..H7 are the numbered half-states; TWH/TWL form one n_wait-requested Tw.
    typedef enum logic [3:0] {
        S_IDLE,
        S_H0, S_H1, S_H2, S_H3, S_H4, S_H5, S_H6, S_H7,
        S_TWH, S_TWL
    } state_t;

    state_t        state;
    logic [CW-1:0] div_cnt;
    logic          half_tick;
    logic [1:0]    op_q;
    logic          is_io;
    logic          is_wr;
    logic          sample_pt;
    logic          wait_ok;

    assign half_tick = (div_cnt == DIV_LAST);
    assign is_io     = op_q[1];
    assign is_wr     = op_q[0];

    // n_wait is examined at the end of T2 for memory, at the end of the mandatory Tw for I/O,
    // and again at the end of every inserted Tw.
    assign sample_pt = ((state == S_H3) && !is_io) ||
                       ((state == S_H5) &&  is_io) ||
                       (state == S_TWL);

`ifdef ZX_BUS_INITIATOR_WAIT_EN
    assign wait_ok = bus.n_wait;
`else
    logic unused_n_wait;
    assign wait_ok       = 1'b1;
    assign unused_n_wait = bus.n_wait;
`endif

    assign bus.n_m1 = 1'b1;

    // NOTE: asynchronous active-low reset; the reset branch clears every register so strobes drop off the bus immediately.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            div_cnt <= half_tick ? '0 : div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= '0;
            busy       <= 1'b0;
            ack        <= 1'b0;
            rdata      <= '0;
            bus.xa     <= '0;
            bus.xd_o   <= '0;
            bus.xd_oe  <= 1'b0;
            bus.n_mreq <= 1'b1;
            bus.n_iorq <= 1'b1;
            bus.n_rd   <= 1'b1;
            bus.n_wr   <= 1'b1;
        end else begin
            ack <= 1'b0;
            if (ack) begin
                busy <= 1'b0;
            end
            if (half_tick) begin
                if (sample_pt) begin
                    if (!wait_ok) begin
                        state <= S_TWH;
                    end else begin
                        state <= is_io ? S_H6 : S_H4;
                        if (!is_wr) begin
                            rdata <= bus.xd_i;
                        end
                    end
                end else begin
                    case (state)
                        S_IDLE: begin
                            if (req) begin
                                op_q     <= op;
                                bus.xa   <= addr;
                                bus.xd_o <= wdata;
                                busy     <= 1'b1;
                                state    <= S_H0;
                            end
                        end
                        S_H0: begin
                            state     <= S_H1;
                            bus.xd_oe <= is_wr;
                            if (!is_io) begin
                                bus.n_mreq <= 1'b0;
                                bus.n_rd   <= is_wr;
                            end
                        end
                        S_H1: begin
                            state <= S_H2;
                            if (is_io) begin
                                bus.n_iorq <= 1'b0;
                                bus.n_rd   <= is_wr;
                                bus.n_wr   <= !is_wr;
                            end
                        end
                        S_H2: begin
                            state <= S_H3;
                            if (!is_io && is_wr) begin
                                bus.n_wr <= 1'b0;
                            end
                        end
                        S_H3: state <= S_H4;
                        S_H4: begin
                            state <= S_H5;
                            if (!is_io) begin
                                bus.n_mreq <= 1'b1;
                                bus.n_rd   <= 1'b1;
                                bus.n_wr   <= 1'b1;
                            end
                        end
                        S_H5: begin
                            state     <= S_IDLE;
                            ack       <= 1'b1;
                            bus.xd_oe <= 1'b0;
                        end
                        S_H6: begin
                            state      <= S_H7;
                            bus.n_iorq <= 1'b1;
                            bus.n_rd   <= 1'b1;
                            bus.n_wr   <= 1'b1;
                        end
                        S_H7: begin
                            state     <= S_IDLE;
                            ack       <= 1'b1;
                            bus.xd_oe <= 1'b0;
                        end
                        S_TWH:   state <= S_TWL;
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    // Strobe exclusivity and handshake shape must hold on every cycle outside reset.
    a_rd_wr_excl: assert property (@(posedge clk28) disable iff (!rst_n)
        !(!bus.n_rd && !bus.n_wr));
    a_mreq_iorq_excl: assert property (@(posedge clk28) disable iff (!rst_n)
        !(!bus.n_mreq && !bus.n_iorq));
    a_ack_pulse: assert property (@(posedge clk28) disable iff (!rst_n)
        ack |=> !ack);
    a_ack_busy: assert property (@(posedge clk28) disable iff (!rst_n)
        ack |-> busy);

endmodule

// File: tb/tb_zx_bus_initiator.sv
`timescale 1ns/1ps
// Scoreboard bench for zx_bus_initiator: directed bus cycles queue their expected address, data and
// strobe timing at issue; a negedge monitor checks them on every ack.
module tb_zx_bus_initiator;
    localparam int HALF_DIV = 4;
    localparam logic [1:0] MEM_RD = 2'b00;
    localparam logic [1:0] MEM_WR = 2'b01;
    localparam logic [1:0] IO_RD  = 2'b10;
    localparam logic [1:0] IO_WR  = 2'b11;
`ifdef ZX_BUS_INITIATOR_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          lat;
        int          mreq;
        int          iorq;
        int          rd;
        int          wr;
        int          oe;
    } exp_t;

    logic        clk28 = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [15:0] addr  = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  rdata;
    logic        ack;
    logic        busy;

    zx_bus_initiator_if bus();

    zx_bus_initiator #(.HALF_DIV(HALF_DIV)) dut (
        .clk28 (clk28),
        .rst_n (rst_n),
        .req   (req),
        .op    (op),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ack   (ack),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk28 = ~clk28;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         n_vec = 0;
    int         n_err = 0;
    int         ack_count = 0;
    int         excl_bad = 0;
    int         m_lat = 0, m_mreq = 0, m_iorq = 0, m_rd = 0, m_wr = 0, m_oe = 0, m_xd_bad = 0;
    bit         m_prev_ack = 1'b0;
    logic [7:0] model_rdata = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Hand-derived for HALF_DIV=4: one half-state is 4 clk28, every inserted Tw adds 8.
    function automatic exp_t make_exp(input logic [1:0] o, input logic [15:0] a,
                                      input logic [7:0] wd, input logic [7:0] rd, input int tw);
        exp_t e;
        e.addr = a; e.wdata = wd; e.rdata = rd;
        case (o)
            MEM_RD:  begin e.lat = 24; e.mreq = 16; e.iorq = 0;  e.rd = 16; e.wr = 0;  e.oe = 0;  end
            MEM_WR:  begin e.lat = 24; e.mreq = 16; e.iorq = 0;  e.rd = 0;  e.wr = 8;  e.oe = 20; end
            IO_RD:   begin e.lat = 32; e.mreq = 0;  e.iorq = 20; e.rd = 20; e.wr = 0;  e.oe = 0;  end
            default: begin e.lat = 32; e.mreq = 0;  e.iorq = 20; e.rd = 0;  e.wr = 20; e.oe = 28; end
        endcase
        e.lat += 8 * tw;
        if (e.mreq != 0) e.mreq += 8 * tw;
        if (e.iorq != 0) e.iorq += 8 * tw;
        if (e.rd   != 0) e.rd   += 8 * tw;
        if (e.wr   != 0) e.wr   += 8 * tw;
        if (e.oe   != 0) e.oe   += 8 * tw;
        return e;
    endfunction

    // Monitor: accumulates strobe activity while busy and scores it against the queue on ack.
    always @(negedge clk28) begin
        if (!rst_n) begin
            m_lat = 0; m_mreq = 0; m_iorq = 0; m_rd = 0; m_wr = 0; m_oe = 0; m_xd_bad = 0;
            m_prev_ack = 1'b0;
        end else begin
            if ((!bus.n_rd && !bus.n_wr) || (!bus.n_mreq && !bus.n_iorq) || !bus.n_m1)
                excl_bad++;
            if (m_prev_ack)
                check("busy_after_ack", busy, 1'b0);
            m_prev_ack = ack;
            if (ack) begin
                ack_count++;
                if (sb_q.size() == 0) begin
                    check("unexpected_ack", ack, 1'b0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("xa",        bus.xa, mon_e.addr);
                    check("rdata",     rdata,  mon_e.rdata);
                    check("busy_at_ack", busy, 1'b1);
                    check("latency",   m_lat,  mon_e.lat);
                    check("mreq_low",  m_mreq, mon_e.mreq);
                    check("iorq_low",  m_iorq, mon_e.iorq);
                    check("rd_low",    m_rd,   mon_e.rd);
                    check("wr_low",    m_wr,   mon_e.wr);
                    check("xd_oe_high", m_oe,  mon_e.oe);
                    check("xd_o_bad",  m_xd_bad, 0);
                end
                m_lat = 0; m_mreq = 0; m_iorq = 0; m_rd = 0; m_wr = 0; m_oe = 0; m_xd_bad = 0;
            end else if (busy) begin
                m_lat++;
                if (!bus.n_mreq) m_mreq++;
                if (!bus.n_iorq) m_iorq++;
                if (!bus.n_rd)   m_rd++;
                if (!bus.n_wr)   m_wr++;
                if (bus.xd_oe) begin
                    m_oe++;
                    if (sb_q.size() > 0 && bus.xd_o !== sb_q[0].wdata) m_xd_bad++;
                end
            end
        end
    end

    task automatic wait_busy(output bit ok);
        for (int i = 0; i < 64 && !busy; i++) @(negedge clk28);
        ok = busy;
        if (!ok) check("accept_timeout", busy, 1'b1);
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 400 && !ack; i++) @(negedge clk28);
        if (!ack) check("ack_timeout", ack, 1'b1);
    endtask

    // Called at the first negedge after acceptance; scrambles the request inputs and plays n_wait.
    task automatic finish_cycle(input logic [1:0] o, input logic [15:0] a, input logic [7:0] wd,
                                input int nlow);
        int rel;
        bit got;
        rel   = (o[1] ? 24 : 16) + 8 * (nlow - 1) + 4;
        req   = 1'b0;
        op    = ~o;
        addr  = ~a;
        wdata = ~wd;
        if (nlow > 0) bus.n_wait = 1'b0;
        got = 1'b0;
        for (int i = 1; i <= 400 && !got; i++) begin
            @(negedge clk28);
            if (i >= rel) bus.n_wait = 1'b1;
            if (ack) got = 1'b1;
        end
        bus.n_wait = 1'b1;
        if (!got) check("ack_timeout", ack, 1'b1);
    endtask

    task automatic run_cycle(input logic [1:0] o, input logic [15:0] a, input logic [7:0] wd,
                             input logic [7:0] xdi, input int nlow);
        bit ok;
        if (!o[0]) model_rdata = xdi;
        sb_q.push_back(make_exp(o, a, wd, model_rdata, WAIT_EN ? nlow : 0));
        @(negedge clk28);
        op = o; addr = a; wdata = wd; bus.xd_i = xdi; req = 1'b1;
        wait_busy(ok);
        if (ok) finish_cycle(o, a, wd, nlow);
        else    req = 1'b0;
    endtask

    initial begin
        int g;
        int acks_before;
        bit ok;
        bus.xd_i   = 8'h00;
        bus.n_wait = 1'b1;
        repeat (3) @(negedge clk28);
        check("rst_n_mreq", bus.n_mreq, 1'b1);
        check("rst_n_iorq", bus.n_iorq, 1'b1);
        check("rst_n_rd",   bus.n_rd,   1'b1);
        check("rst_n_wr",   bus.n_wr,   1'b1);
        check("rst_n_m1",   bus.n_m1,   1'b1);
        check("rst_xd_oe",  bus.xd_oe,  1'b0);
        check("rst_ack",    ack,        1'b0);
        check("rst_busy",   busy,       1'b0);
        check("rst_xa",     bus.xa,     16'h0000);
        check("rst_xd_o",   bus.xd_o,   8'h00);
        check("rst_rdata",  rdata,      8'h00);

        // First half-tick after reset release accepts a request already pending.
        model_rdata = 8'hA5;
        sb_q.push_back(make_exp(MEM_RD, 16'h1234, 8'h00, model_rdata, 0));
        op = MEM_RD; addr = 16'h1234; wdata = 8'h00; bus.xd_i = 8'hA5; req = 1'b1;
        rst_n = 1'b1;
        g = 0;
        do begin
            @(negedge clk28);
            g++;
        end while (!busy && g < 32);
        check("first_tick_after_reset", g, HALF_DIV);
        finish_cycle(MEM_RD, 16'h1234, 8'h00, 0);

        run_cycle(IO_WR,  16'h00FE, 8'h07, 8'h00, 0);
        run_cycle(MEM_WR, 16'h8000, 8'h3C, 8'h00, 2);
        run_cycle(IO_RD,  16'h1FFE, 8'h00, 8'h5A, 1);
        run_cycle(MEM_WR, 16'hABCD, 8'h96, 8'h00, 0);

        // Back-to-back: req held across the ack, next cycle starts on the following half-tick.
        model_rdata = 8'h81;
        sb_q.push_back(make_exp(MEM_RD, 16'hFFFF, 8'h00, model_rdata, 0));
        model_rdata = 8'hC3;
        sb_q.push_back(make_exp(IO_RD, 16'h0000, 8'h00, model_rdata, 0));
        @(negedge clk28);
        op = MEM_RD; addr = 16'hFFFF; wdata = 8'h00; bus.xd_i = 8'h81; req = 1'b1;
        wait_busy(ok);
        op = IO_RD; addr = 16'h0000;
        wait_ack();
        bus.xd_i = 8'hC3;
        g = 0;
        do begin
            @(negedge clk28);
            g++;
        end while (!busy && g < 32);
        check("b2b_gap", g, HALF_DIV);
        req = 1'b0;
        wait_ack();

        // Reset during H2 of a memory read: strobes release at once and no ack follows.
        @(negedge clk28);
        op = MEM_RD; addr = 16'h4321; wdata = 8'h00; bus.xd_i = 8'h99; req = 1'b1;
        wait_busy(ok);
        req = 1'b0;
        repeat (9) @(negedge clk28);
        check("pre_rst_n_rd", bus.n_rd, 1'b0);
        acks_before = ack_count;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_n_mreq", bus.n_mreq, 1'b1);
        check("mid_rst_n_rd",   bus.n_rd,   1'b1);
        check("mid_rst_xd_oe",  bus.xd_oe,  1'b0);
        check("mid_rst_busy",   busy,       1'b0);
        check("mid_rst_ack",    ack,        1'b0);
        repeat (3) @(negedge clk28);
        check("mid_rst_xa",    bus.xa, 16'h0000);
        check("mid_rst_rdata", rdata,  8'h00);
        model_rdata = 8'h00;
        rst_n = 1'b1;
        repeat (40) @(negedge clk28);
        check("no_ack_after_rst", ack_count, acks_before);

        run_cycle(MEM_RD, 16'h0F0F, 8'h00, 8'h3C, 0);

        repeat (8) @(negedge clk28);
        check("strobe_exclusive", excl_bad, 0);
        check("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at time limit, expected finished");
        $fatal(1);
    end

endmodule
